// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: merges the I-cache and D-cache request ports onto one
// RAM port, one transaction in flight, data priority with an instruction anti-starvation limit.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ramerr
);

  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0]  TMO_MAX    = 8'(TIMEOUT);
  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [1:0]  RAM_ERROR  = 2'd3;
  localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  state_t      state_q;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic [7:0]  tmo_q;
  logic [7:0]  tmo_d;
  logic        wr_q;
  logic        iwait_q;
  logic        dwait_q;
  logic [31:0] iload_q;
  logic [31:0] dload_q;
  logic        ramren_q;
  logic        ramwen_q;
  logic [31:0] ramaddr_q;
  logic [31:0] ramstore_q;
  logic        ramerr_q;
  logic        withdraw_s;
  logic        timeout_s;
  logic [31:0] resp_load_s;

  // tmo_d counts the current grant cycle too, so a grant lasts at most TIMEOUT cycles
  always_comb begin
    tmo_d     = tmo_q + 8'd1;
    timeout_s = (tmo_d == TMO_MAX);
    if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
    case (state_q)
      GRANT_I: withdraw_s = ~iREN;
      GRANT_D: withdraw_s = ~(dREN | dWEN);
      default: withdraw_s = 1'b0;
    endcase
    if (ramstate == RAM_ACCESS) begin
      resp_load_s = wr_q ? 32'h0000_0000 : ramload;
    end else begin
      resp_load_s = ERR_WORD;
    end
  end

  // Arbitration / transaction state machine with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      starve_q   <= 4'd0;
      tmo_q      <= 8'd0;
      wr_q       <= 1'b0;
      iwait_q    <= 1'b1;
      dwait_q    <= 1'b1;
      iload_q    <= 32'h0000_0000;
      dload_q    <= 32'h0000_0000;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= 32'h0000_0000;
      ramstore_q <= 32'h0000_0000;
      ramerr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          iwait_q <= 1'b1;
          dwait_q <= 1'b1;
          tmo_q   <= 8'd0;
          if (iREN && (starve_q == STARVE_MAX)) begin
            state_q   <= GRANT_I;
            starve_q  <= 4'd0;
            wr_q      <= 1'b0;
            ramaddr_q <= iaddr;
            ramren_q  <= 1'b1;
            ramwen_q  <= 1'b0;
          end else if (dREN || dWEN) begin
            state_q    <= GRANT_D;
            starve_q   <= iREN ? starve_d : starve_q;
            wr_q       <= dWEN;
            ramaddr_q  <= daddr;
            ramstore_q <= dstore;
            ramren_q   <= ~dWEN;
            ramwen_q   <= dWEN;
          end else if (iREN) begin
            state_q   <= GRANT_I;
            starve_q  <= 4'd0;
            wr_q      <= 1'b0;
            ramaddr_q <= iaddr;
            ramren_q  <= 1'b1;
            ramwen_q  <= 1'b0;
          end else begin
            state_q  <= IDLE;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
          end
        end
        GRANT_I, GRANT_D: begin
          tmo_q <= tmo_d;
          if ((ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR) || timeout_s) begin
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            if (ramstate != RAM_ACCESS) begin
              ramerr_q <= 1'b1;
            end else begin
              ramerr_q <= ramerr_q;
            end
            if (state_q == GRANT_I) begin
              state_q <= RESP_I;
              iwait_q <= 1'b0;
              iload_q <= resp_load_s;
            end else begin
              state_q <= RESP_D;
              dwait_q <= 1'b0;
              dload_q <= resp_load_s;
            end
          end else if (withdraw_s) begin
            state_q  <= IDLE;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        RESP_I, RESP_D: begin
          state_q <= IDLE;
          iwait_q <= 1'b1;
          dwait_q <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          iwait_q  <= 1'b1;
          dwait_q  <= 1'b1;
          ramren_q <= 1'b0;
          ramwen_q <= 1'b0;
        end
      endcase
    end
  end

  assign iwait    = iwait_q;
  assign dwait    = dwait_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign ramerr   = ramerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized transactions, checked
// against a transaction-level model of arbitration priority, starvation and RAM latency.
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ramerr;

  int checks   = 0;
  int failures = 0;
  int starve_m = 0;
  bit erm      = 1'b0;

  mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_iwait"},    32'(iwait),    32'd1);
    chk({tag, "_dwait"},    32'(dwait),    32'd1);
    chk({tag, "_iload"},    iload,         32'd0);
    chk({tag, "_dload"},    dload,         32'd0);
    chk({tag, "_ramREN"},   32'(ramREN),   32'd0);
    chk({tag, "_ramWEN"},   32'(ramWEN),   32'd0);
    chk({tag, "_ramaddr"},  ramaddr,       32'd0);
    chk({tag, "_ramstore"}, ramstore,      32'd0);
    chk({tag, "_ramerr"},   32'(ramerr),   32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_iwait"},  32'(iwait),  32'd1);
    chk({tag, "_dwait"},  32'(dwait),  32'd1);
    chk({tag, "_ramREN"}, 32'(ramREN), 32'd0);
    chk({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
    chk({tag, "_ramerr"}, 32'(ramerr), 32'(erm));
  endtask

  task automatic drop(input int who);
    if (who == 1) begin
      iREN = 1'b0;
    end else begin
      dREN = 1'b0;
      dWEN = 1'b0;
    end
  endtask

  // Starts at a negedge with the DUT idle and requests driven; returns at a negedge, DUT idle.
  // lat: grant cycle in which the RAM answers; err: answer is ERROR; wd: grant cycle of withdrawal.
  task automatic run_txn(input int lat, input bit err, input int wd,
                         input logic [31:0] ldval, output int winner);
    bit          wr;
    bit          resp;
    bit          done;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] exp_load;
    resp = 1'b0;
    done = 1'b0;
    exp_load = 32'd0;
    winner = 0;
    if (iREN && starve_m == STARVE) winner = 1;
    else if (dREN || dWEN)           winner = 2;
    else if (iREN)                   winner = 1;
    if (winner == 2 && iREN) starve_m = (starve_m < STARVE) ? starve_m + 1 : starve_m;
    if (winner == 1) starve_m = 0;
    wr    = (winner == 2) && dWEN;
    addr  = (winner == 1) ? iaddr : daddr;
    store = dstore;
    @(posedge CLK);
    if (winner == 0) begin
      @(negedge CLK);
      chk_quiet("idle");
      return;
    end
    for (int k = 1; k <= TMO && !done; k++) begin
      @(negedge CLK);
      chk("grant_ren",   32'(ramREN), 32'(!wr));
      chk("grant_wen",   32'(ramWEN), 32'(wr));
      chk("grant_addr",  ramaddr, addr);
      if (wr) chk("grant_store", ramstore, store);
      chk("grant_iwait", 32'(iwait), 32'd1);
      chk("grant_dwait", 32'(dwait), 32'd1);
      chk("grant_err",   32'(ramerr), 32'(erm));
      ramload = $urandom;
      if (k == lat && !err) begin
        ramstate = 2'd2; ramload = ldval; exp_load = wr ? 32'd0 : ldval;
        resp = 1'b1; done = 1'b1;
      end else if (k == lat) begin
        ramstate = 2'd3; exp_load = BAD; erm = 1'b1; resp = 1'b1; done = 1'b1;
      end else if (k == TMO) begin
        ramstate = 2'd1; exp_load = BAD; erm = 1'b1; resp = 1'b1; done = 1'b1;
      end else if (k == wd) begin
        ramstate = 2'd1; drop(winner); done = 1'b1;
      end else begin
        ramstate = 2'd1;
      end
      @(posedge CLK);
    end
    @(negedge CLK);
    ramstate = 2'd0;
    if (resp) begin
      chk("resp_iwait",  32'(iwait),  (winner == 1) ? 32'd0 : 32'd1);
      chk("resp_dwait",  32'(dwait),  (winner == 2) ? 32'd0 : 32'd1);
      chk("resp_load",   (winner == 1) ? iload : dload, exp_load);
      chk("resp_ramREN", 32'(ramREN), 32'd0);
      chk("resp_ramWEN", 32'(ramWEN), 32'd0);
      chk("resp_err",    32'(ramerr), 32'(erm));
      drop(winner);
      @(posedge CLK);
      @(negedge CLK);
      chk_quiet("post_resp");
    end else begin
      chk_quiet("withdrawn");
    end
  endtask

  initial begin
    int          w;
    int          lat;
    int          wd;
    bit          err;
    logic [1:0]  r;
    RST = 1'b1; iREN = 1'b0; iaddr = 32'd0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = 2'd0;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    chk_reset("reset");
    RST = 1'b0;

    // single instruction read, ACCESS in third grant cycle
    iREN = 1'b1; iaddr = 32'h40;
    run_txn(3, 1'b0, 0, 32'h8C010004, w);

    // simultaneous I read and D write: D first, then I
    iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; dREN = 1'b0;
    daddr = 32'h100; dstore = 32'hDEADBEEF;
    run_txn(2, 1'b0, 0, 32'h1234_5678, w);
    run_txn(1, 1'b0, 0, 32'h0BAD_F00D, w);

    // continuous D reads with I pending: four D, then I, then D again
    iREN = 1'b1; iaddr = 32'h200;
    for (int n = 0; n < 6; n++) begin
      if (!dREN) begin dREN = 1'b1; daddr = 32'h300 + 32'(n); end
      run_txn(1, 1'b0, 0, $urandom, w);
    end
    drop(1); drop(2);

    // ACCESS in the last allowed grant cycle wins over timeout
    dREN = 1'b1; daddr = 32'h400;
    run_txn(TMO, 1'b0, 0, 32'hCAFE_0001, w);

    // RAM stuck BUSY: timeout after TMO grant cycles
    dREN = 1'b1; daddr = 32'h404;
    run_txn(TMO + 5, 1'b0, 0, 32'd0, w);

    // reset during a grant clears everything and suppresses the response
    iREN = 1'b1; iaddr = 32'h500;
    @(posedge CLK);
    @(negedge CLK); ramstate = 2'd1;
    chk("rstg_ren", 32'(ramREN), 32'd1);
    @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk_reset("rst_mid_grant");
    RST = 1'b0; iREN = 1'b0; ramstate = 2'd0; starve_m = 0; erm = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk_quiet("after_rst");

    // ERROR during a D read; ramerr sticky afterwards
    dREN = 1'b1; daddr = 32'h600;
    run_txn(2, 1'b1, 0, 32'd0, w);
    iREN = 1'b1; iaddr = 32'h604;
    run_txn(1, 1'b0, 0, 32'h5555_AAAA, w);

    // D request withdrawn in the second grant cycle
    dREN = 1'b1; daddr = 32'h700;
    run_txn(5, 1'b0, 2, 32'd0, w);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      if (!iREN) begin iREN = 1'($urandom_range(0, 1)); iaddr = $urandom; end
      if (!dREN && !dWEN) begin
        r = 2'($urandom_range(0, 3));
        dREN = r[0]; dWEN = r[1]; daddr = $urandom; dstore = $urandom;
      end
      lat = $urandom_range(1, 10);
      err = ($urandom_range(0, 7) == 0);
      wd  = 0;
      if ($urandom_range(0, 7) == 0 && lat >= 2)
        wd = $urandom_range(1, ((lat < TMO) ? lat : TMO) - 1);
      run_txn(lat, err, wd, $urandom, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
